// File: rtl/cram_pkg.sv
// Shared types and constants for the constant-memory loader.
package cram_pkg;

    localparam int unsigned CM_AW  = 3;
    localparam int unsigned CM_DW  = 20;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    // Default constant-table indices used by the processor.
    localparam logic [CM_AW-1:0] SRC_BASE  = 3'd3;
    localparam logic [CM_AW-1:0] DST_BASE  = 3'd4;
    localparam logic [CM_AW-1:0] SRC_LAST  = 3'd5;
    localparam logic [CM_AW-1:0] SRC_WIDTH = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_WR   = 3'd4,
        ST_CK   = 3'd5,
        ST_DONE = 3'd6
    } cram_state_t;

    // Next constant-memory address, wrapping at the top of the table.
    function automatic logic [CM_AW-1:0] addr_next(input logic [CM_AW-1:0] a);
        return a + CM_AW'(1);
    endfunction

endpackage

// File: rtl/cram_word_asm.sv
// Little-endian byte-to-20-bit word assembler with a bytes-received count.
module cram_word_asm
    import cram_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [CM_DW-1:0]  word,
    output logic              hi_nib_err_c
);

    logic [1:0] idx_q;

    // Third byte carries only four data bits; a nonzero upper nibble is an error.
    assign hi_nib_err_c = byte_en && (idx_q == 2'd2) && (byte_in[7:4] != 4'h0);

    // Place each accepted byte into its lane of the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            word  <= '0;
            idx_q <= 2'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
        end else if (byte_en) begin
            case (idx_q)
                2'd0: begin
                    word[7:0] <= byte_in;
                    idx_q     <= 2'd1;
                end
                2'd1: begin
                    word[15:8] <= byte_in;
                    idx_q      <= 2'd2;
                end
                default: begin
                    word[19:16] <= byte_in[3:0];
                    idx_q       <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cram_loader.sv
// Constant-memory loader: assembles a byte stream into 20-bit words and writes
// them to consecutive constant-memory entries, then pulses done.
// Optional trailing XOR checksum byte: define CRAM_LOADER_CHECKSUM_EN.
module cram_loader
    import cram_pkg::*;
#(
    parameter int unsigned START_ADDR = 3,
    parameter int unsigned NUM_WORDS  = 4
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              cm_w,
    output logic [CM_AW-1:0]  cm_waddr,
    output logic [CM_DW-1:0]  cm_din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
    localparam logic [CM_AW-1:0] START_A  = CM_AW'(START_ADDR);

    cram_state_t       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CM_AW-1:0]  addr_q, addr_d;
    logic              err_d;
    logic              xfer;
    logic              asm_clear;
    logic              byte_en;
    logic              nib_err_c;
`ifdef CRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] ck_q, ck_d;
`endif

    assign xfer = in_valid && in_ready;

    cram_word_asm u_asm (
        .clock        (clock),
        .reset        (reset),
        .clear        (asm_clear),
        .byte_en      (byte_en),
        .byte_in      (in_data),
        .word         (cm_din),
        .hi_nib_err_c (nib_err_c)
    );

    // Next-state, counters and error flag.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = err;
        asm_clear = 1'b0;
        byte_en   = 1'b0;
`ifdef CRAM_LOADER_CHECKSUM_EN
        ck_d      = ck_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_B0;
                    count_d   = '0;
                    addr_d    = START_A;
                    err_d     = 1'b0;
                    asm_clear = 1'b1;
`ifdef CRAM_LOADER_CHECKSUM_EN
                    ck_d      = '0;
`endif
                end
            end
            ST_B0: begin
                if (xfer) begin
                    byte_en = 1'b1;
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (xfer) begin
                    byte_en = 1'b1;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (xfer) begin
                    byte_en = 1'b1;
                    state_d = ST_WR;
                    if (nib_err_c) err_d = 1'b1;
                end
            end
            ST_WR: begin
                if (count_q == LAST_CNT) begin
`ifdef CRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    count_d = count_q + CNT_W'(1);
                    addr_d  = addr_next(addr_q);
                    state_d = ST_B0;
                end
            end
`ifdef CRAM_LOADER_CHECKSUM_EN
            ST_CK: begin
                if (xfer) begin
                    state_d = ST_DONE;
                    if (in_data != ck_q) err_d = 1'b1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef CRAM_LOADER_CHECKSUM_EN
        if (byte_en) ck_d = ck_q ^ in_data;
`endif
    end

    // State, bookkeeping and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            addr_q   <= '0;
            err      <= 1'b0;
            in_ready <= 1'b0;
            cm_w     <= 1'b0;
            cm_waddr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CRAM_LOADER_CHECKSUM_EN
            ck_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err      <= err_d;
            in_ready <= (state_d == ST_B0) || (state_d == ST_B1) ||
                        (state_d == ST_B2) || (state_d == ST_CK);
            cm_w     <= (state_d == ST_WR);
            busy     <= (state_d != ST_IDLE);
            done     <= (state_d == ST_DONE);
            if (state_d == ST_WR) cm_waddr <= addr_q;
`ifdef CRAM_LOADER_CHECKSUM_EN
            ck_q     <= ck_d;
`endif
        end
    end

endmodule

// File: tb/tb_cram_loader.sv
// Self-checking bench for cram_loader (default and wrapped-address instances).
module tb_cram_loader;

`ifdef CRAM_LOADER_CHECKSUM_EN
    localparam int CK_EN = 1;
`else
    localparam int CK_EN = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready_a, cm_w_a, busy_a, done_a, err_a;
    logic [2:0]  cm_waddr_a;
    logic [19:0] cm_din_a;
    logic        in_ready_b, cm_w_b, busy_b, done_b, err_b;
    logic [2:0]  cm_waddr_b;
    logic [19:0] cm_din_b;

    cram_loader dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .cm_w(cm_w_a), .cm_waddr(cm_waddr_a), .cm_din(cm_din_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    cram_loader #(.START_ADDR(6), .NUM_WORDS(3)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .cm_w(cm_w_b), .cm_waddr(cm_waddr_b), .cm_din(cm_din_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Write/done monitor sampled just after each rising edge.
    logic [2:0]  wa_q[$];
    logic [19:0] wd_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic err_done = 1'b0;
    int   wr_viol  = 0;

    always @(posedge clock) begin
        #1;
        if (cm_w_a) begin
            wa_q.push_back(cm_waddr_a);
            wd_q.push_back(cm_din_a);
            if (in_ready_a || !busy_a) wr_viol = wr_viol + 1;
        end
        if (cm_w_b) begin
            wa_q.push_back(cm_waddr_b);
            wd_q.push_back(cm_din_b);
            if (in_ready_b || !busy_b) wr_viol = wr_viol + 1;
        end
        if (done_a) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            err_done = err_a;
        end
        if (done_b) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            err_done = err_b;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stimulus table: three stream bytes and the word they must produce.
    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [19:0] data;
        logic        nerr;
    } vec_t;

    vec_t tbl[12];

    // Offer bytes one per accepted transfer; mode 0 always valid, 1 toggling, 2 random.
    task automatic feed(input logic sel, input logic [7:0] bytes[$], input int mode, input int start_at);
        int   idx = 0;
        int   it  = 0;
        logic rdy, v;
        while (idx < bytes.size() && it < 500) begin
            rdy = sel ? in_ready_b : in_ready_a;
            case (mode)
                0:       v = 1'b1;
                1:       v = (it % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            in_data  = v ? bytes[idx] : 8'($urandom);
            if (sel) start_b = (it == start_at);
            else     start_a = (it == start_at);
            if (v && rdy) idx++;
            it++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        if (idx < bytes.size()) check("feed_timeout", 32'(idx), 32'(bytes.size()));
    endtask

    // One complete run with expected words and error flag supplied by the caller.
    task automatic do_run(input logic sel, input logic [7:0] bytes_in[$], input logic [19:0] exp_d[$],
                          input logic exp_nerr, input logic bad_ck, input int mode,
                          input int start_at, input logic chk_lat, input string tag);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic       exp_err;
        int         n, sa, wbase, dbase, vbase, t0, waited;
        bytes = bytes_in;
        n  = exp_d.size();
        sa = sel ? 6 : 3;
        x  = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
        if (CK_EN != 0) bytes.push_back(bad_ck ? (x ^ 8'h01) : x);
        exp_err = exp_nerr | ((CK_EN != 0) && bad_ck);
        wbase = wa_q.size();
        dbase = done_cnt;
        vbase = wr_viol;
        @(negedge clock);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        t0 = cyc;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, "_err_clr"}, 32'(sel ? err_b : err_a), 0);
        check({tag, "_busy"}, 32'(sel ? busy_b : busy_a), 1);
        feed(sel, bytes, mode, start_at);
        waited = 0;
        while (done_cnt == dbase && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check({tag, "_done_cnt"}, 32'(done_cnt - dbase), 1);
        if (chk_lat) check({tag, "_latency"}, 32'(done_cyc - t0), 32'(4 * n + 1 + CK_EN));
        check({tag, "_err_at_done"}, 32'(err_done), 32'(exp_err));
        @(negedge clock);
        check({tag, "_busy_after"}, 32'(sel ? busy_b : busy_a), 0);
        check({tag, "_done_after"}, 32'(sel ? done_b : done_a), 0);
        check({tag, "_err_sticky"}, 32'(sel ? err_b : err_a), 32'(exp_err));
        check({tag, "_wr_qual"}, 32'(wr_viol - vbase), 0);
        check({tag, "_nwrites"}, 32'(wa_q.size() - wbase), 32'(n));
        for (int i = 0; i < n && (wbase + i) < wa_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[wbase + i]), 32'((sa + i) % 8));
            check($sformatf("%s_data%0d", tag, i), 32'(wd_q[wbase + i]), 32'(exp_d[i]));
        end
    endtask

    task automatic tbl_run(input logic sel, input int first, input int n, input int mode,
                           input int start_at, input logic bad_ck, input logic chk_lat, input string tag);
        logic [7:0]  bq[$];
        logic [19:0] dq[$];
        logic        ne = 1'b0;
        for (int i = first; i < first + n; i++) begin
            bq.push_back(tbl[i].b0);
            bq.push_back(tbl[i].b1);
            bq.push_back(tbl[i].b2);
            dq.push_back(tbl[i].data);
            ne = ne | tbl[i].nerr;
        end
        do_run(sel, bq, dq, ne, bad_ck, mode, start_at, chk_lat, tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready_a), 0);
        check({tag, "_cm_w"},     32'(cm_w_a), 0);
        check({tag, "_waddr"},    32'(cm_waddr_a), 0);
        check({tag, "_din"},      32'(cm_din_a), 0);
        check({tag, "_busy"},     32'(busy_a), 0);
        check({tag, "_done"},     32'(done_a), 0);
        check({tag, "_err"},      32'(err_a), 0);
        check({tag, "_busy_b"},   32'(busy_b), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  rb[$];
    logic [19:0] rd[$];
    logic [7:0]  b0, b1, b2;
    logic        rne;
    int          wb;

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 8'h00, 20'h00000, 1'b0};
        tbl[1]  = '{8'h10, 8'h27, 8'h00, 20'd10000,  1'b0};
        tbl[2]  = '{8'h43, 8'h20, 8'h00, 20'd8259,   1'b0};
        tbl[3]  = '{8'h76, 8'h00, 8'h00, 20'd118,    1'b0};
        tbl[4]  = '{8'h01, 8'h00, 8'h00, 20'd1,      1'b0};
        tbl[5]  = '{8'h02, 8'h00, 8'h00, 20'd2,      1'b0};
        tbl[6]  = '{8'h03, 8'h00, 8'h00, 20'd3,      1'b0};
        tbl[7]  = '{8'h34, 8'h12, 8'hF5, 20'h51234,  1'b1};
        tbl[8]  = '{8'hFF, 8'hFF, 8'h0F, 20'hFFFFF,  1'b0};
        tbl[9]  = '{8'hAA, 8'h55, 8'h03, 20'h355AA,  1'b0};
        tbl[10] = '{8'h00, 8'h00, 8'h10, 20'h00000,  1'b1};
        tbl[11] = '{8'h01, 8'h80, 8'h07, 20'h78001,  1'b0};

        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("por");

        tbl_run(1'b0, 0, 4, 0, -1, 1'b0, 1'b1, "t1_stream");
        tbl_run(1'b0, 0, 4, 1, -1, 1'b0, 1'b0, "t2_toggle");
        tbl_run(1'b1, 4, 3, 0, -1, 1'b0, 1'b1, "t3_wrap");
        tbl_run(1'b0, 7, 4, 1, -1, 1'b0, 1'b0, "t4_nib_err");
        tbl_run(1'b0, 0, 4, 0,  4, 1'b0, 1'b0, "t5_start_busy");

        // Abort after five bytes: one word written, then reset clears everything.
        rb.delete();
        rb.push_back(8'h00); rb.push_back(8'h00); rb.push_back(8'hF0);
        rb.push_back(8'h10); rb.push_back(8'h27);
        wb = wa_q.size();
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        feed(1'b0, rb, 0, -1);
        check("rst_err_before", 32'(err_a), 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("rst_mid");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_nwrites", 32'(wa_q.size() - wb), 1);
        if (wa_q.size() > wb) begin
            check("rst_addr0", 32'(wa_q[wb]), 3);
            check("rst_data0", 32'(wd_q[wb]), 0);
        end
        check_reset_vals("rst_idle");

        // Start and reset in the same cycle: reset wins.
        reset   = 1'b1;
        start_a = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        start_a = 1'b0;
        @(negedge clock);
        check("rst_start_busy", 32'(busy_a), 0);
        check("rst_start_rdy",  32'(in_ready_a), 0);

        tbl_run(1'b0, 0, 4, 0, -1, 1'b0, 1'b1, "t6_clean");
        tbl_run(1'b0, 8, 4, 2, -1, 1'b0, 1'b0, "t7_rand_valid");
        tbl_run(1'b0, 0, 4, 0, -1, 1'b1, 1'b0, "t8_bad_ck");

        // Randomised runs checked against an arithmetic model of the stream.
        for (int r = 0; r < 24; r++) begin
            int n;
            logic sel;
            sel = 1'(r % 2);
            n   = sel ? 3 : 4;
            rb.delete();
            rd.delete();
            rne = 1'b0;
            for (int w = 0; w < n; w++) begin
                b0 = 8'($urandom);
                b1 = 8'($urandom);
                b2 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
                rb.push_back(b0);
                rb.push_back(b1);
                rb.push_back(b2);
                rd.push_back(20'(b0) + (20'(b1) << 8) + (20'(b2 % 16) << 16));
                if (b2 / 16 != 0) rne = 1'b1;
            end
            do_run(sel, rb, rd, rne, ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                   -1, 1'b0, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
